// File: rtl/store_monitor_pkg.sv
// -----------------------------------------------------------------------------
// store_monitor_pkg
// Shared types for the store monitor: FSM state encoding, failure codes and
// the index-width helper used to size table and counter ports.
// -----------------------------------------------------------------------------
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fail_code_e;

  // A one-entry table still needs a one-bit index port.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_monitor_table.sv
// -----------------------------------------------------------------------------
// store_monitor_table
// Expected-store table: DEPTH entries of {addr, data}, cleared by reset.
//
// Ports
//   clk, reset          clock / asynchronous active-high reset
//   wr_en               write strobe (already qualified by the caller)
//   wr_idx              entry to write; indices >= DEPTH are dropped
//   wr_addr, wr_data    entry contents
//   rd_idx              combinational read index (one bit wider than wr_idx so
//                       it can be driven directly by a 0..DEPTH match count)
//   rd_addr, rd_data    entry contents, 0 when rd_idx >= DEPTH
// -----------------------------------------------------------------------------
module store_monitor_table
  import store_monitor_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int IDXW  = idx_width(DEPTH),
  localparam int CNTW  = IDXW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CNTW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  logic [WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_idx} < DEPTH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (wr_ok) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Reading past the end (match count == DEPTH) yields zeros rather than
  // aliasing onto a real entry.
  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    if (rd_idx < DEPTH_C) begin
      rd_addr = addr_mem[rd_idx[IDXW-1:0]];
      rd_data = data_mem[rd_idx[IDXW-1:0]];
    end
  end

endmodule

// File: rtl/store_monitor.sv
// -----------------------------------------------------------------------------
// store_monitor
// Watches the store port of a core and checks that it performs an expected,
// ordered list of stores within a cycle budget. Stores to one benign address
// can be filtered out. Result is sticky until the next start or reset.
//
// State table
//   state   | meaning
//   IDLE    | table may be loaded, stores ignored
//   RUN     | comparing stores against entry[match_cnt], timer running
//   PASS    | all num_exp entries matched in order (pass=1)
//   FAIL    | unexpected store or timeout (fail=1, fail_code says which)
//
// Ports
//   clk, reset                   clock / asynchronous active-high reset
//   memwrite, dataadr, writedata monitored store port
//   ld_en, ld_idx, ld_addr,
//   ld_data                      table load (IDLE only)
//   num_exp                      number of active entries, 0..DEPTH
//   ign_en, ign_addr             benign-address filter
//   start                        begin/restart checking from any state
//   pass, fail, fail_code        registered status
//   match_cnt                    entries matched so far
//   fail_addr, fail_data         store that caused a mismatch (0 on timeout)
// -----------------------------------------------------------------------------
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int IDXW    = idx_width(DEPTH),
  localparam int CNTW    = IDXW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             ld_en,
  input  logic [IDXW-1:0]  ld_idx,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [CNTW-1:0]  num_exp,
  input  logic             ign_en,
  input  logic [WIDTH-1:0] ign_addr,
  input  logic             start,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNTW-1:0]  match_cnt,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  fail_code_e       fc_q, fc_d;
  logic [CNTW-1:0]  match_q, match_d, match_inc;
  logic [TW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fd_q, fd_d;

  logic [WIDTH-1:0] tbl_addr, tbl_data;
  logic             hit, benign;

  store_monitor_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ld_en && (state_q == ST_IDLE)),
    .wr_idx  (ld_idx),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_idx  (match_q),
    .rd_addr (tbl_addr),
    .rd_data (tbl_data)
  );

  assign hit       = ({dataadr, writedata} == {tbl_addr, tbl_data});
  assign benign    = ign_en && (dataadr == ign_addr);
  assign match_inc = match_q + CNTW'(1);

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    match_d = match_q;
    cyc_d   = cyc_q;
    fa_d    = fa_q;
    fd_d    = fd_q;

    if (state_q == ST_RUN) begin
      cyc_d = cyc_q + TW'(1);
      if (num_exp == '0) begin
        state_d = ST_PASS;
      end else if (memwrite && hit) begin
        // A hit wins over the benign filter even if the addresses coincide.
        match_d = match_inc;
        if (match_inc == num_exp) state_d = ST_PASS;
      end else if (memwrite && !benign) begin
        state_d = ST_FAIL;
        fc_d    = FC_MISMATCH;
        fa_d    = dataadr;
        fd_d    = writedata;
      end

      // Timeout only applies when this cycle made no other decision, so a
      // final match on the last budget cycle still passes.
      if ((state_d == ST_RUN) && (cyc_q == TO_LAST)) begin
        state_d = ST_FAIL;
        fc_d    = FC_TIMEOUT;
        fa_d    = '0;
        fd_d    = '0;
      end
    end

    // Restart overrides everything, including a store in the same cycle.
    if (start) begin
      state_d = ST_RUN;
      fc_d    = FC_NONE;
      match_d = '0;
      cyc_d   = '0;
      fa_d    = '0;
      fd_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fc_q    <= FC_NONE;
      match_q <= '0;
      cyc_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      match_q <= match_d;
      cyc_q   <= cyc_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign fail_code = fc_q;
  assign match_cnt = match_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;

endmodule

// File: tb/tb_store_monitor.sv
module tb_store_monitor;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          memwrite = 1'b0;
  logic [W-1:0]  dataadr = '0, writedata = '0;
  logic          ld_en = 1'b0;
  logic [1:0]    ld_idx = '0;
  logic [W-1:0]  ld_addr = '0, ld_data = '0;
  logic [2:0]    num_exp = '0;
  logic          ign_en = 1'b0;
  logic [W-1:0]  ign_addr = '0;
  logic          start = 1'b0;

  logic          pass, fail;
  logic [1:0]    fail_code;
  logic [2:0]    match_cnt;
  logic [W-1:0]  fail_addr, fail_data;

  store_monitor #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .num_exp   (num_exp),
    .ign_en    (ign_en),
    .ign_addr  (ign_addr),
    .start     (start),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code),
    .match_cnt (match_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  always #5 clk = ~clk;

  // {pass, fail, fail_code, match_cnt, fail_addr, fail_data}
  typedef logic [70:0] st_t;
  typedef struct {
    string name;
    st_t   v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic st_t mk(input logic p, input logic f, input logic [1:0] c,
                             input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] d);
    return {p, f, c, m, a, d};
  endfunction

  function automatic st_t obs();
    return {pass, fail, fail_code, match_cnt, fail_addr, fail_data};
  endfunction

  task automatic push(input string n, input st_t v);
    exp_t x;
    x.name = n;
    x.v    = v;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = idx; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic setup_basic();
    do_reset();
    load(2'd0, 32'd84, 32'd7);
    num_exp  = 3'd1;
    ign_en   = 1'b1;
    ign_addr = 32'd80;
  endtask

  task automatic load_three();
    do_reset();
    load(2'd0, 32'd4,  32'd1);
    load(2'd1, 32'd8,  32'd2);
    load(2'd2, 32'd12, 32'd3);
    num_exp = 3'd3;
  endtask

  task automatic test_reset();
    do_reset();
    push("reset_state", mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    store(32'd5, 32'd5);
    push("idle_ignores_store", mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_pass_with_ignore();
    setup_basic();
    do_start();
    store(32'd80, 32'd0);
    store(32'd80, 32'd3);
    push("ignored_stores", mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    push("pass_after_match", mk(1, 0, 0, 1, 0, 0));
    store(32'd84, 32'd7);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    push("pass_holds", mk(1, 0, 0, 1, 0, 0));
    store(32'd99, 32'd99);
    tick();
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_mismatch();
    // table kept across restart from PASS
    do_start();
    push("mismatch_data", mk(0, 1, 1, 0, 84, 6));
    store(32'd84, 32'd6);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    push("fail_holds", mk(0, 1, 1, 0, 84, 6));
    store(32'd84, 32'd7);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_no_ignore();
    setup_basic();
    ign_en = 1'b0;
    do_start();
    push("filter_off", mk(0, 1, 1, 0, 80, 0));
    store(32'd80, 32'd0);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_timeout();
    setup_basic();
    do_start();
    for (int i = 0; i < TO - 1; i++) tick();
    push("no_timeout_early", mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    push("timeout", mk(0, 1, 2, 0, 0, 0));
    tick();
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_pass_beats_timeout();
    setup_basic();
    do_start();
    for (int i = 0; i < TO - 1; i++) tick();
    push("pass_on_last_cycle", mk(1, 0, 0, 1, 0, 0));
    store(32'd84, 32'd7);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_order();
    load_three();
    ign_en = 1'b0;
    do_start();
    store(32'd4, 32'd1);
    push("first_match", mk(0, 0, 0, 1, 0, 0));
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    push("out_of_order", mk(0, 1, 1, 1, 12, 3));
    store(32'd12, 32'd3);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    do_start();
    store(32'd4, 32'd1);
    store(32'd8, 32'd2);
    push("in_order_pass", mk(1, 0, 0, 3, 0, 0));
    store(32'd12, 32'd3);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_match_beats_ignore();
    load_three();
    ign_en   = 1'b1;
    ign_addr = 32'd4;
    do_start();
    push("match_over_ignore", mk(0, 0, 0, 1, 0, 0));
    store(32'd4, 32'd1);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    push("ignore_after_match", mk(0, 0, 0, 1, 0, 0));
    store(32'd4, 32'd9);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_num_exp_zero();
    setup_basic();
    num_exp = 3'd0;
    do_start();
    push("num_exp_zero", mk(1, 0, 0, 0, 0, 0));
    store(32'd200, 32'd200);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_back_to_back_restart();
    load_three();
    ign_en = 1'b0;
    do_start();
    store(32'd4, 32'd1);
    // restart with a bogus store and a load attempt in the same cycle
    start = 1'b1; memwrite = 1'b1; dataadr = 32'd77; writedata = 32'd77;
    ld_en = 1'b1; ld_idx = 2'd1; ld_addr = 32'd99; ld_data = 32'd99;
    tick();
    start = 1'b0; memwrite = 1'b0; ld_en = 1'b0;
    push("restart_mid_run", mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    store(32'd4, 32'd1);
    store(32'd8, 32'd2);
    push("load_ignored_in_run", mk(1, 0, 0, 3, 0, 0));
    store(32'd12, 32'd3);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_reset_mid_run();
    load_three();
    ign_en = 1'b0;
    do_start();
    store(32'd4, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    push("async_reset", mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    reset = 1'b0;
    tick();
    push("idle_after_reset", mk(0, 0, 0, 0, 0, 0));
    store(32'd4, 32'd1);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    // entry 0 must now read as 0/0
    num_exp = 3'd1;
    do_start();
    push("table_cleared", mk(1, 0, 0, 1, 0, 0));
    store(32'd0, 32'd0);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass_with_ignore();
    test_mismatch();
    test_no_ignore();
    test_timeout();
    test_pass_beats_timeout();
    test_order();
    test_match_beats_ignore();
    test_num_exp_zero();
    test_back_to_back_restart();
    test_reset_mid_run();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
